// File: rtl/cdb_arbiter.sv
// Purpose : round-robin arbiter for the common data bus; grants one execution unit per cycle and drives the registered CDB broadcast.
// Latency : xmit is combinational in the request cycle; CDB_data/CDB_source/CDB_write/tag_error appear one clock after the grant.
// Backpressure: a unit holds rts/data/tag until it sees xmit at a rising edge; ungranted units simply wait, nothing is dropped.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   rts                 - per-unit ready-to-send request, bit i = unit i
//   unit_data           - unit i result in [i*DATA_W +: DATA_W] (signed)
//   unit_source         - unit i producing RS tag in [i*TAG_W +: TAG_W]
//   xmit                - one-hot grant, combinational, zero while reset is high
//   CDB_data/CDB_source - registered broadcast value and tag (hold when idle)
//   CDB_write           - registered broadcast valid
//   tag_error           - registered one-cycle pulse: granted unit presented tag 0
//   broadcast_count, conflict_count - present only when CDB_STATS_EN is defined
//
// Build option: define CDB_STATS_EN to add the broadcast/conflict counters.
module cdb_arbiter #(
    parameter int N_UNITS = 2,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_UNITS-1:0]         rts,
    input  logic [N_UNITS*DATA_W-1:0]  unit_data,
    input  logic [N_UNITS*TAG_W-1:0]   unit_source,
    output logic [N_UNITS-1:0]         xmit,
    output logic signed [DATA_W-1:0]   CDB_data,
    output logic [TAG_W-1:0]           CDB_source,
    output logic                       CDB_write,
`ifdef CDB_STATS_EN
    output logic [31:0]                broadcast_count,
    output logic [31:0]                conflict_count,
`endif
    output logic                       tag_error
);

    localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    // ptr holds the most recently granted unit; the search starts just after it.
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;

    // Walk the rotation from the far end back toward ptr+1 so the last hit
    // written is the first requester in round-robin order (no early exit needed).
    // With N_UNITS=1 every offset maps to index 0, so the grant is rts[0].
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        idx     = 0;
        idx_p   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        xmit    = '0;
        for (int k = N_UNITS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_UNITS) begin
                idx = idx - N_UNITS;
            end
            idx_p = PTR_W'(idx);
            if (rts[idx_p]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_p;
            end
        end
        if (reset) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld) begin
            xmit[gnt_idx] = 1'b1;
        end
    end

    assign sel_data = unit_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_tag  = unit_source[int'(gnt_idx)*TAG_W +: TAG_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            CDB_data   <= '0;
            CDB_source <= '0;
            CDB_write  <= 1'b0;
            tag_error  <= 1'b0;
            ptr        <= PTR_W'(N_UNITS - 1);
        end else begin
            CDB_write <= gnt_vld;
            // Tag 0 is never a valid RS; flag it but still broadcast.
            tag_error <= gnt_vld && (sel_tag == '0);
            if (gnt_vld) begin
                CDB_data   <= sel_data;
                CDB_source <= sel_tag;
                ptr        <= gnt_idx;
            end
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            broadcast_count <= '0;
            conflict_count  <= '0;
        end else begin
            if (gnt_vld) begin
                broadcast_count <= broadcast_count + 32'd1;
            end
            if ($countones(rts) > 1) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // DUT A: default 2-unit configuration
    logic [1:0]         rts_a;
    logic [63:0]        data_a;
    logic [11:0]        src_a;
    logic [1:0]         xmit_a;
    logic signed [31:0] cdb_data_a;
    logic [5:0]         cdb_src_a;
    logic               cdb_wr_a;
    logic               terr_a;

    // DUT B: 3-unit configuration
    logic [2:0]         rts_b;
    logic [95:0]        data_b;
    logic [17:0]        src_b;
    logic [2:0]         xmit_b;
    logic signed [31:0] cdb_data_b;
    logic [5:0]         cdb_src_b;
    logic               cdb_wr_b;
    logic               terr_b;

`ifdef CDB_STATS_EN
    logic [31:0] bc_a, cc_a, bc_b, cc_b;
`endif

    cdb_arbiter #(.N_UNITS(2), .DATA_W(32), .TAG_W(6)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .rts         (rts_a),
        .unit_data   (data_a),
        .unit_source (src_a),
        .xmit        (xmit_a),
        .CDB_data    (cdb_data_a),
        .CDB_source  (cdb_src_a),
        .CDB_write   (cdb_wr_a),
`ifdef CDB_STATS_EN
        .broadcast_count (bc_a),
        .conflict_count  (cc_a),
`endif
        .tag_error   (terr_a)
    );

    cdb_arbiter #(.N_UNITS(3), .DATA_W(32), .TAG_W(6)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .rts         (rts_b),
        .unit_data   (data_b),
        .unit_source (src_b),
        .xmit        (xmit_b),
        .CDB_data    (cdb_data_b),
        .CDB_source  (cdb_src_b),
        .CDB_write   (cdb_wr_b),
`ifdef CDB_STATS_EN
        .broadcast_count (bc_b),
        .conflict_count  (cc_b),
`endif
        .tag_error   (terr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table (2-unit DUT) ----------------
    typedef struct {
        logic        rst;
        logic [1:0]  rts;
        logic [31:0] d0, d1;
        logic [5:0]  t0, t1;
        logic [1:0]  x;
        logic        w;
        logic [31:0] d;
        logic [5:0]  s;
        logic        te;
    } vec_t;

    vec_t tv[19];

    // ---------------- reference model ----------------
    // Priority is kept as an explicit rotation of unit numbers: the granted
    // unit is rotated to the back, everyone after it moves to the front.
    int          m_n;
    int          m_order[$];
    logic [31:0] m_data;
    logic [5:0]  m_src;
    logic        m_write, m_terr;
    logic [31:0] m_bc, m_cc;

    function automatic int model_grant(input logic [7:0] r);
        foreach (m_order[k]) begin
            if (r[m_order[k]]) return m_order[k];
        end
        return -1;
    endfunction

    task automatic model_clock(input logic rst, input logic [7:0] r,
                               input logic [255:0] d, input logic [47:0] t);
        int g;
        int x;
        if (rst) begin
            m_order.delete();
            for (int i = 0; i < m_n; i++) m_order.push_back(i);
            m_data = 0; m_src = 0; m_write = 0; m_terr = 0; m_bc = 0; m_cc = 0;
        end else begin
            g = model_grant(r);
            if ($countones(r) > 1) m_cc++;
            if (g >= 0) begin
                m_data  = d[g*32 +: 32];
                m_src   = t[g*6 +: 6];
                m_write = 1'b1;
                m_terr  = (m_src == 6'd0);
                m_bc++;
                while (m_order[$] != g) begin
                    x = m_order.pop_front();
                    m_order.push_back(x);
                end
            end else begin
                m_write = 1'b0;
                m_terr  = 1'b0;
            end
        end
    endtask

    task automatic rstep(input int which, input logic rst, input logic [7:0] r,
                         input logic [255:0] d, input logic [47:0] t);
        int          g;
        logic [31:0] ex;
        reset = rst;
        if (which == 0) begin
            rts_a = r[1:0]; data_a = d[63:0]; src_a = t[11:0];
        end else begin
            rts_b = r[2:0]; data_b = d[95:0]; src_b = t[17:0];
        end
        #1;
        g  = rst ? -1 : model_grant(r);
        ex = (g < 0) ? 32'd0 : (32'd1 << g);
        check($sformatf("rnd%0d xmit", which), (which == 0) ? 32'(xmit_a) : 32'(xmit_b), ex);
        @(posedge clock);
        model_clock(rst, r, d, t);
        #1;
        if (which == 0) begin
            check("rnd0 write", 32'(cdb_wr_a), 32'(m_write));
            check("rnd0 data",  cdb_data_a,     m_data);
            check("rnd0 src",   32'(cdb_src_a), 32'(m_src));
            check("rnd0 terr",  32'(terr_a),    32'(m_terr));
`ifdef CDB_STATS_EN
            check("rnd0 bcnt", bc_a, m_bc);
            check("rnd0 ccnt", cc_a, m_cc);
`endif
        end else begin
            check("rnd1 write", 32'(cdb_wr_b), 32'(m_write));
            check("rnd1 data",  cdb_data_b,     m_data);
            check("rnd1 src",   32'(cdb_src_b), 32'(m_src));
            check("rnd1 terr",  32'(terr_b),    32'(m_terr));
`ifdef CDB_STATS_EN
            check("rnd1 bcnt", bc_b, m_bc);
            check("rnd1 ccnt", cc_b, m_cc);
`endif
        end
    endtask

    task automatic random_phase(input int which, input int n, input int cycles);
        logic [7:0]   r;
        logic [255:0] d;
        logic [47:0]  t;
        logic         rst;
        m_n = n;
        for (int c = 0; c < cycles; c++) begin
            r = 8'($urandom) & 8'((1 << n) - 1);
            d = '0;
            t = '0;
            for (int u = 0; u < n; u++) begin
                d[u*32 +: 32] = $urandom;
                t[u*6 +: 6]   = 6'($urandom_range(0, 3));
            end
            rst = (c == 0) || ($urandom_range(0, 29) == 0);
            rstep(which, rst, r, d, t);
        end
        // park this DUT idle
        if (which == 0) rts_a = '0; else rts_b = '0;
    endtask

    initial begin
        logic [2:0] e3;

        reset = 1'b1;
        rts_a = '0; data_a = '0; src_a = '0;
        rts_b = '0; data_b = '0; src_b = '0;

        //            rst  rts    d0            d1      t0 t1  x      w  d             s  te
        tv[0]  = '{1'b1, 2'b11, 32'd0,        32'd0,  0, 0, 2'b00, 0, 32'd0,        0, 0};
        tv[1]  = '{1'b0, 2'b01, 32'd5,        32'd0,  3, 0, 2'b01, 1, 32'd5,        3, 0};
        tv[2]  = '{1'b0, 2'b00, 32'd5,        32'd0,  3, 0, 2'b00, 0, 32'd5,        3, 0};
        tv[3]  = '{1'b1, 2'b00, 32'd0,        32'd0,  0, 0, 2'b00, 0, 32'd0,        0, 0};
        tv[4]  = '{1'b0, 2'b11, 32'd10,       32'd20, 1, 9, 2'b01, 1, 32'd10,       1, 0};
        tv[5]  = '{1'b0, 2'b11, 32'd10,       32'd20, 1, 9, 2'b10, 1, 32'd20,       9, 0};
        tv[6]  = '{1'b0, 2'b11, 32'd10,       32'd20, 1, 9, 2'b01, 1, 32'd10,       1, 0};
        tv[7]  = '{1'b0, 2'b11, 32'd10,       32'd20, 1, 9, 2'b10, 1, 32'd20,       9, 0};
        tv[8]  = '{1'b0, 2'b00, 32'd10,       32'd20, 1, 9, 2'b00, 0, 32'd20,       9, 0};
        tv[9]  = '{1'b0, 2'b01, 32'hFFFFFFF9, 32'd0,  2, 0, 2'b01, 1, 32'hFFFFFFF9, 2, 0};
        tv[10] = '{1'b0, 2'b01, 32'hFFFFFFF8, 32'd0,  2, 0, 2'b01, 1, 32'hFFFFFFF8, 2, 0};
        tv[11] = '{1'b0, 2'b01, 32'hFFFFFFF7, 32'd0,  2, 0, 2'b01, 1, 32'hFFFFFFF7, 2, 0};
        tv[12] = '{1'b0, 2'b10, 32'd0,        32'd42, 0, 0, 2'b10, 1, 32'd42,       0, 1};
        tv[13] = '{1'b0, 2'b00, 32'd0,        32'd42, 0, 0, 2'b00, 0, 32'd42,       0, 0};
        tv[14] = '{1'b0, 2'b11, 32'd1,        32'd2,  4, 5, 2'b01, 1, 32'd1,        4, 0};
        tv[15] = '{1'b0, 2'b11, 32'd1,        32'd2,  4, 5, 2'b10, 1, 32'd2,        5, 0};
        tv[16] = '{1'b1, 2'b11, 32'd1,        32'd2,  4, 5, 2'b00, 0, 32'd0,        0, 0};
        tv[17] = '{1'b0, 2'b11, 32'd1,        32'd2,  4, 5, 2'b01, 1, 32'd1,        4, 0};
        tv[18] = '{1'b0, 2'b00, 32'd1,        32'd2,  4, 5, 2'b00, 0, 32'd1,        4, 0};

        #1;
        for (int i = 0; i < 19; i++) begin
            reset  = tv[i].rst;
            rts_a  = tv[i].rts;
            data_a = {tv[i].d1, tv[i].d0};
            src_a  = {tv[i].t1, tv[i].t0};
            #1;
            check($sformatf("vec%0d xmit", i), 32'(xmit_a), 32'(tv[i].x));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d write", i), 32'(cdb_wr_a),  32'(tv[i].w));
            check($sformatf("vec%0d data", i),  cdb_data_a,      tv[i].d);
            check($sformatf("vec%0d src", i),   32'(cdb_src_a), 32'(tv[i].s));
            check($sformatf("vec%0d terr", i),  32'(terr_a),    32'(tv[i].te));
`ifdef CDB_STATS_EN
            if (i == 7) begin
                check("alt conflict_count", cc_a, 32'd4);
                check("alt broadcast_count", bc_a, 32'd4);
            end
`endif
        end
        rts_a = '0;

        // 3-unit DUT: all requesting continuously -> 0,1,2,0,1,2
        reset  = 1'b1;
        rts_b  = '0;
        data_b = {32'd30, 32'd20, 32'd10};
        src_b  = {6'd3, 6'd2, 6'd1};
        @(posedge clock);
        #1;
        reset = 1'b0;
        rts_b = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            e3 = 3'b001 << (i % 3);
            check($sformatf("n3 cyc%0d xmit", i), 32'(xmit_b), 32'(e3));
            @(posedge clock);
            #1;
            check($sformatf("n3 cyc%0d src", i), 32'(cdb_src_b), 32'(i % 3 + 1));
        end
`ifdef CDB_STATS_EN
        check("n3 broadcast_count", bc_b, 32'd6);
`endif
        rts_b = '0;

        random_phase(0, 2, 300);
        random_phase(1, 3, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
